l1_line_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate cache between the multicycle LC-3b control/datapath memory port and the 128-bit physical memory.
- Serves 16-bit word reads and byte-masked writes from the CPU side (mem_read/mem_write/mem_byte_enable/mem_resp).
- Fills and evicts whole 16-byte lines over a request/response pmem port.
- Hits complete combinationally in the request cycle; misses stall the CPU FSM by withholding mem_resp.

---
 rtl/l1_line_cache.sv | 130 +++++++++++++
 tb/tb_l1_line_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between the LC-3b memory
// port and 128-bit line-wide physical memory. Hits answer in the request cycle.
module l1_line_cache #(
  parameter int NUM_LINES  = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int OFF  = $clog2(LINE_BYTES);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = 16 - OFF - IDX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  // state is left as a plain named signal so checkers can bind to it
  state_t state, state_next;

  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAGW-1:0]      tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];

  logic [TAGW-1:0]  addr_tag;
  logic [IDX-1:0]   addr_idx;
  logic [OFF-2:0]   addr_word;
  logic [OFF+2:0]   lane_lsb;
  logic [127:0]     line_data;
  logic [15:0]      hit_word;
  logic [15:0]      merged_word;
  logic             req, hit, write_hit, fill;
  logic             unused_bits;

  assign addr_tag    = mem_address[15:OFF+IDX];
  assign addr_idx    = mem_address[OFF+IDX-1:OFF];
  assign addr_word   = mem_address[OFF-1:1];
  assign lane_lsb    = {addr_word, 4'h0};
  assign unused_bits = &{1'b0, mem_address[0]};

  assign req       = mem_read | mem_write;
  assign line_data = data_arr[addr_idx];
  assign hit_word  = line_data[lane_lsb +: 16];
  assign hit       = req && valid[addr_idx] && (tag_arr[addr_idx] == addr_tag);
  // A simultaneous read and write is served as a read only.
  assign write_hit = (state == IDLE) && hit && mem_write && !mem_read;
  assign fill      = (state == ALLOCATE) && pmem_resp;

  assign merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : hit_word[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : hit_word[7:0]};

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (mem_read) mem_rdata = hit_word;
        end else if (req) begin
          state_next = (valid[addr_idx] && dirty[addr_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[addr_idx], addr_idx, {OFF{1'b0}}};
        pmem_wdata   = line_data;
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:OFF], {OFF{1'b0}}};
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Requests are withdrawn as soon as reset is seen, not one edge later.
    if (!rst_n) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      mem_resp   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid[addr_idx] <= 1'b1;
        dirty[addr_idx] <= 1'b0;
      end else if (write_hit) begin
        dirty[addr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; validity alone guards them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill) begin
        data_arr[addr_idx] <= pmem_rdata;
        tag_arr[addr_idx]  <= addr_tag;
      end else if (write_hit) begin
        data_arr[addr_idx][lane_lsb +: 16] <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_l1_line_cache.sv
// Directed bench for l1_line_cache: a fixed-latency line memory model plus
// hand-computed expectations for hits, clean/dirty misses and reset mid-fill.
module tb_l1_line_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [127:0] pmem_mem [4096];
  int           pm_cnt = 0;
  int           rd_cycles = 0;
  int           wr_cycles = 0;
  logic [15:0]  last_rd_addr = '0;
  logic [15:0]  last_wr_addr = '0;

  logic [15:0]  rdata;
  int           lat;

  l1_line_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- physical memory model: answers after 3 request cycles ----
  always @(negedge clk) begin
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end
    if (pmem_read || pmem_write) begin
      pm_cnt++;
      if (pmem_read) rd_cycles++;
      else           wr_cycles++;
      if (pm_cnt == 3) begin
        if (pmem_write) begin
          pmem_mem[pmem_address[15:4]] = pmem_wdata;
          last_wr_addr = pmem_address;
        end else begin
          pmem_rdata   = pmem_mem[pmem_address[15:4]];
          last_rd_addr = pmem_address;
        end
        pmem_resp = 1'b1;
      end
    end else begin
      pm_cnt = 0;
    end
  end

  // ---- checker ----
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counters();
    rd_cycles = 0;
    wr_cycles = 0;
  endtask

  // Call at posedge+1; returns at posedge+1 after mem_resp with inputs idle.
  task automatic cpu_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd,
                         output logic [15:0] rd_data, output int cycles);
    bit done = 0;
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    rd_data = '0;
    cycles  = -1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        rd_data = mem_rdata;
        cycles  = c;
        done    = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00; mem_wdata = '0;
  endtask

  initial begin
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        pmem_mem[l][w*16 +: 16] = {l[7:0], 4'h0, w[3:0]};
    for (int w = 0; w < 8; w++)
      pmem_mem[1][w*16 +: 16] = w[15:0];

    // ---- reset ----
    rst_n = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_resp",   mem_resp, 0);
    check("rst_pmem_read",  pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_mem_rdata",  mem_rdata, 0);
    check("rst_pmem_addr",  pmem_address, 0);
    @(posedge clk); #1;

    // ---- clean miss fill of line 0x0010 ----
    clear_counters();
    cpu_req(1, 0, 16'h0010, 2'b00, 16'h0, rdata, lat);
    check("fill_rdata", rdata, 16'h0000);
    check("fill_lat", lat, 4);
    check("fill_rd_cycles", rd_cycles, 3);
    check("fill_rd_addr", last_rd_addr, 16'h0010);
    check("fill_wr_cycles", wr_cycles, 0);

    // ---- read hit, last word ----
    clear_counters();
    cpu_req(1, 0, 16'h001E, 2'b00, 16'h0, rdata, lat);
    check("hit_rdata", rdata, 16'h0007);
    check("hit_lat", lat, 0);
    check("hit_no_pmem", rd_cycles + wr_cycles, 0);

    // ---- low-byte write hit ----
    cpu_req(0, 1, 16'h0012, 2'b01, 16'hBEEF, rdata, lat);
    check("wr_hit_lat", lat, 0);
    cpu_req(1, 0, 16'h0012, 2'b00, 16'h0, rdata, lat);
    check("wr_hit_readback", rdata, 16'h00EF);

    // ---- dirty eviction: same index 1, tag 1 ----
    clear_counters();
    cpu_req(1, 0, 16'h0090, 2'b00, 16'h0, rdata, lat);
    check("evict_wr_addr", last_wr_addr, 16'h0010);
    check("evict_wr_cycles", wr_cycles, 3);
    check("evict_word1", pmem_mem[1][31:16], 16'h00EF);
    check("evict_rd_addr", last_rd_addr, 16'h0090);
    check("evict_rdata", rdata, 16'h0900);
    check("evict_lat", lat, 7);

    // ---- write-allocate, high byte only ----
    clear_counters();
    cpu_req(0, 1, 16'h0224, 2'b10, 16'h1200, rdata, lat);
    check("walloc_lat", lat, 4);
    check("walloc_rd_addr", last_rd_addr, 16'h0220);
    cpu_req(1, 0, 16'h0224, 2'b00, 16'h0, rdata, lat);
    check("walloc_readback", rdata, 16'h1202);

    // ---- reset during ALLOCATE ----
    mem_address = 16'h0330; mem_read = 1'b1;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (pmem_read) seen = 1;
      end
      check("alloc_started", seen, 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0;
    #1 check("rst_drops_pmem_read", pmem_read, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pmem_read", pmem_read, 0);
    check("post_rst_mem_resp", mem_resp, 0);
    check("post_rst_pmem_addr", pmem_address, 0);
    @(posedge clk); #1;
    clear_counters();
    cpu_req(1, 0, 16'h0330, 2'b00, 16'h0, rdata, lat);
    check("rerd_lat", lat, 4);
    check("rerd_rd_cycles", rd_cycles, 3);
    check("rerd_rdata", rdata, 16'h3300);

    // ---- back-to-back hits ----
    cpu_req(1, 0, 16'h0010, 2'b00, 16'h0, rdata, lat);
    check("b2b_fill_rdata", rdata, 16'h0000);
    clear_counters();
    mem_address = 16'h0010; mem_read = 1'b1;
    @(negedge clk);
    check("b2b_resp0", mem_resp, 1);
    check("b2b_rdata0", mem_rdata, 16'h0000);
    @(posedge clk); #1;
    mem_address = 16'h0014;
    @(negedge clk);
    check("b2b_resp1", mem_resp, 1);
    check("b2b_rdata1", mem_rdata, 16'h0002);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("b2b_idle_resp", mem_resp, 0);
    check("b2b_no_pmem", rd_cycles + wr_cycles, 0);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
